// File: rtl/sprite_index_pipeline.sv
// ---------------------------------------------------------------------------
// sprite_index_pipeline
//
// Per-pixel layer resolver sitting in front of the palette lookups. For each
// VGA pixel it hit-tests the character, monster and bullet sprites against
// positions latched once per frame, drives the ROM addresses for every
// layer, absorbs the 1-cycle synchronous ROM read and resolves priority and
// transparency into a 4-bit palette index plus a layer select. The sync and
// blank signals travel through the same pipeline, so everything leaves
// aligned. Fixed latency is 3 cycles, with no stall.
//
// Ports
//   Clk, Reset_n                    pixel clock, async active-low reset
//   DrawX, DrawY                    current pixel column / row
//   blank_in, hs_in, vs_in          1 = visible; active-low syncs
//   char_x/y, mon_x/y, bul_x/y      sprite top-left positions (live)
//   mon_alive, bul_active           monster / bullet layer enables (live)
//   bg_addr, char_addr,
//   mon_addr, bul_addr              ROM addresses, registered (t+1)
//   bg_q, char_q, mon_q, bul_q      ROM data, valid one cycle after address
//   pal_idx, layer_sel              resolved pixel (t+3);
//                                   layer 0 bg, 1 mon, 2 char, 3 bullet
//   blank_out, hs_out, vs_out       syncs aligned with pal_idx
// ---------------------------------------------------------------------------
module sprite_index_pipeline #(
    parameter int CHAR_W     = 32,
    parameter int CHAR_H     = 32,
    parameter int MON_W      = 32,
    parameter int MON_H      = 32,
    parameter int BUL_W      = 8,
    parameter int BUL_H      = 8,
    parameter int MON_FRAMES = 2,
    parameter int ANIM_DIV   = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [9:0]  char_x,
    input  logic [9:0]  char_y,
    input  logic [9:0]  mon_x,
    input  logic [9:0]  mon_y,
    input  logic [9:0]  bul_x,
    input  logic [9:0]  bul_y,
    input  logic        mon_alive,
    input  logic        bul_active,
    output logic [16:0] bg_addr,
    output logic [9:0]  char_addr,
    output logic [10:0] mon_addr,
    output logic [5:0]  bul_addr,
    input  logic [3:0]  bg_q,
    input  logic [3:0]  char_q,
    input  logic [3:0]  mon_q,
    input  logic [3:0]  bul_q,
    output logic [3:0]  pal_idx,
    output logic [1:0]  layer_sel,
    output logic        blank_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int AF_W = (MON_FRAMES > 1) ? $clog2(MON_FRAMES) : 1;
    localparam int FC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {
        LAYER_BG   = 2'd0,
        LAYER_MON  = 2'd1,
        LAYER_CHAR = 2'd2,
        LAYER_BUL  = 2'd3
    } layer_e;

    typedef struct packed {
        logic bul;
        logic chr;
        logic mon;
    } hits_t;

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } sync_t;

    // Reset state of the sync pipeline: blanked, syncs inactive (high).
    localparam sync_t SYNC_RST = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

    // -----------------------------------------------------------------------
    // Frame-boundary detection and shadow position registers
    // -----------------------------------------------------------------------
    logic       vs_prev_q;
    logic       vs_fall;

    logic [9:0] char_x_q, char_y_q, mon_x_q, mon_y_q, bul_x_q, bul_y_q;
    logic       char_en_q, mon_en_q, bul_en_q;

    assign vs_fall = vs_prev_q & ~vs_in;

    // The character has no external enable; char_en_q keeps it hidden from
    // reset until the first latched frame so a (0,0) shadow never shows.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_prev_q <= 1'b1;
            char_x_q  <= '0;
            char_y_q  <= '0;
            mon_x_q   <= '0;
            mon_y_q   <= '0;
            bul_x_q   <= '0;
            bul_y_q   <= '0;
            char_en_q <= 1'b0;
            mon_en_q  <= 1'b0;
            bul_en_q  <= 1'b0;
        end else begin
            vs_prev_q <= vs_in;
            if (vs_fall) begin
                char_x_q  <= char_x;
                char_y_q  <= char_y;
                mon_x_q   <= mon_x;
                mon_y_q   <= mon_y;
                bul_x_q   <= bul_x;
                bul_y_q   <= bul_y;
                char_en_q <= 1'b1;
                mon_en_q  <= mon_alive;
                bul_en_q  <= bul_active;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monster animation sequencing
    // -----------------------------------------------------------------------
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [AF_W-1:0] anim_frame_q, anim_frame_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        anim_frame_d = anim_frame_q;
        if (vs_fall) begin
            if (frame_cnt_q == FC_W'(ANIM_DIV - 1)) begin
                frame_cnt_d  = '0;
                anim_frame_d = (anim_frame_q == AF_W'(MON_FRAMES - 1))
                             ? '0 : anim_frame_q + 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_q  <= '0;
            anim_frame_q <= '0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            anim_frame_q <= anim_frame_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage A: hit tests and ROM address generation
    // -----------------------------------------------------------------------
    // Bounds are compared at 11 bits so an object whose right/bottom edge
    // passes 1023 clips instead of wrapping to a tiny upper bound.
    function automatic logic in_span(input logic [9:0] p,
                                     input logic [9:0] org,
                                     input int         size);
        logic [10:0] lo;
        logic [10:0] hi;
        lo = {1'b0, org};
        hi = lo + 11'(size);
        return ({1'b0, p} >= lo) && ({1'b0, p} < hi);
    endfunction

    hits_t       hits_a_d, hits_a_q;
    sync_t       sync_a_q;
    logic [16:0] bg_addr_d, bg_addr_q;
    logic [9:0]  char_addr_d, char_addr_q;
    logic [10:0] mon_addr_d, mon_addr_q;
    logic [5:0]  bul_addr_d, bul_addr_q;

    logic [9:0]  char_dx, char_dy, mon_dx, mon_dy, bul_dx, bul_dy;

    assign char_dx = DrawX - char_x_q;
    assign char_dy = DrawY - char_y_q;
    assign mon_dx  = DrawX - mon_x_q;
    assign mon_dy  = DrawY - mon_y_q;
    assign bul_dx  = DrawX - bul_x_q;
    assign bul_dy  = DrawY - bul_y_q;

    always_comb begin
        hits_a_d.chr = char_en_q && in_span(DrawX, char_x_q, CHAR_W)
                                 && in_span(DrawY, char_y_q, CHAR_H);
        hits_a_d.mon = mon_en_q  && in_span(DrawX, mon_x_q, MON_W)
                                 && in_span(DrawY, mon_y_q, MON_H);
        hits_a_d.bul = bul_en_q  && in_span(DrawX, bul_x_q, BUL_W)
                                 && in_span(DrawY, bul_y_q, BUL_H);

        // Background is 320x240 upscaled 2x, so drop the LSB of each axis.
        bg_addr_d = 17'(DrawY[9:1]) * 17'd320 + 17'(DrawX[9:1]);

        // Non-hit layers park at address 0 to stay inside each ROM.
        char_addr_d = '0;
        mon_addr_d  = '0;
        bul_addr_d  = '0;
        if (hits_a_d.chr) begin
            char_addr_d = 10'(char_dy) * 10'(CHAR_W) + 10'(char_dx);
        end
        if (hits_a_d.mon) begin
            // Animation frames are stored back-to-back in the monster ROM.
            mon_addr_d = 11'(mon_dy) * 11'(MON_W) + 11'(mon_dx)
                       + 11'(anim_frame_q) * 11'(MON_W * MON_H);
        end
        if (hits_a_d.bul) begin
            bul_addr_d = 6'(bul_dy) * 6'(BUL_W) + 6'(bul_dx);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hits_a_q    <= '0;
            sync_a_q    <= SYNC_RST;
            bg_addr_q   <= '0;
            char_addr_q <= '0;
            mon_addr_q  <= '0;
            bul_addr_q  <= '0;
        end else begin
            hits_a_q    <= hits_a_d;
            sync_a_q    <= '{blank: blank_in, hs: hs_in, vs: vs_in};
            bg_addr_q   <= bg_addr_d;
            char_addr_q <= char_addr_d;
            mon_addr_q  <= mon_addr_d;
            bul_addr_q  <= bul_addr_d;
        end
    end

    assign bg_addr   = bg_addr_q;
    assign char_addr = char_addr_q;
    assign mon_addr  = mon_addr_q;
    assign bul_addr  = bul_addr_q;

    // -----------------------------------------------------------------------
    // Stage B: ROM read in progress; carry flags and syncs one more cycle
    // -----------------------------------------------------------------------
    hits_t hits_b_q;
    sync_t sync_b_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hits_b_q <= '0;
            sync_b_q <= SYNC_RST;
        end else begin
            hits_b_q <= hits_a_q;
            sync_b_q <= sync_a_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage C: priority / transparency resolve
    // -----------------------------------------------------------------------
    logic [3:0] pal_idx_d, pal_idx_q;
    layer_e     layer_sel_d, layer_sel_q;
    sync_t      sync_c_q;

    // Sprite index 0 is transparent; the background is always opaque.
    always_comb begin
        pal_idx_d   = bg_q;
        layer_sel_d = LAYER_BG;
        if (hits_b_q.bul && (bul_q != 4'd0)) begin
            pal_idx_d   = bul_q;
            layer_sel_d = LAYER_BUL;
        end else if (hits_b_q.chr && (char_q != 4'd0)) begin
            pal_idx_d   = char_q;
            layer_sel_d = LAYER_CHAR;
        end else if (hits_b_q.mon && (mon_q != 4'd0)) begin
            pal_idx_d   = mon_q;
            layer_sel_d = LAYER_MON;
        end
        if (!sync_b_q.blank) begin
            pal_idx_d   = 4'd0;
            layer_sel_d = LAYER_BG;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_idx_q   <= '0;
            layer_sel_q <= LAYER_BG;
            sync_c_q    <= SYNC_RST;
        end else begin
            pal_idx_q   <= pal_idx_d;
            layer_sel_q <= layer_sel_d;
            sync_c_q    <= sync_b_q;
        end
    end

    assign pal_idx   = pal_idx_q;
    assign layer_sel = layer_sel_q;
    assign blank_out = sync_c_q.blank;
    assign hs_out    = sync_c_q.hs;
    assign vs_out    = sync_c_q.vs;

endmodule

// File: tb/tb_sprite_index_pipeline.sv
// ---------------------------------------------------------------------------
// tb_sprite_index_pipeline
//
// Directed bench for sprite_index_pipeline. ROM data inputs are driven as
// constants by the bench; every expected address, index and layer below is
// hand-computed from the sprite geometry. Inputs change 1 time unit after
// the rising edge, outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sprite_index_pipeline;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_in, hs_in, vs_in;
    logic [9:0]  char_x, char_y, mon_x, mon_y, bul_x, bul_y;
    logic        mon_alive, bul_active;
    logic [16:0] bg_addr;
    logic [9:0]  char_addr;
    logic [10:0] mon_addr;
    logic [5:0]  bul_addr;
    logic [3:0]  bg_q, char_q, mon_q, bul_q;
    logic [3:0]  pal_idx;
    logic [1:0]  layer_sel;
    logic        blank_out, hs_out, vs_out;

    int n_vec = 0;
    int n_err = 0;

    sprite_index_pipeline dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank_in   (blank_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .char_x     (char_x),
        .char_y     (char_y),
        .mon_x      (mon_x),
        .mon_y      (mon_y),
        .bul_x      (bul_x),
        .bul_y      (bul_y),
        .mon_alive  (mon_alive),
        .bul_active (bul_active),
        .bg_addr    (bg_addr),
        .char_addr  (char_addr),
        .mon_addr   (mon_addr),
        .bul_addr   (bul_addr),
        .bg_q       (bg_q),
        .char_q     (char_q),
        .mon_q      (mon_q),
        .bul_q      (bul_q),
        .pal_idx    (pal_idx),
        .layer_sel  (layer_sel),
        .blank_out  (blank_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One vs falling edge, then vs back high.
    task automatic frame_edge();
        vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
    endtask

    // Present a pixel and let it reach stage A (addresses valid).
    task automatic present(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
    endtask

    // Two more edges bring the presented pixel to the outputs.
    task automatic drain();
        tick();
        tick();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        Reset_n    = 1'b0;
        DrawX      = '0;
        DrawY      = '0;
        blank_in   = 1'b0;
        hs_in      = 1'b1;
        vs_in      = 1'b1;
        char_x     = '0;
        char_y     = '0;
        mon_x      = '0;
        mon_y      = '0;
        bul_x      = '0;
        bul_y      = '0;
        mon_alive  = 1'b0;
        bul_active = 1'b0;
        bg_q       = 4'd4;
        char_q     = 4'd5;
        mon_q      = 4'd0;
        bul_q      = 4'd0;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();

        // ---- Reset mid-line ------------------------------------------------
        blank_in = 1'b1;
        hs_in    = 1'b0;
        present(10, 0);
        check("bg_addr_10_0", bg_addr, 5);
        drain();
        check("pre_rst_hs_out", hs_out, 0);
        check("pre_rst_blank_out", blank_out, 1);
        check("pre_rst_pal_bg", pal_idx, 4);

        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_pal_idx", pal_idx, 0);
        check("rst_layer_sel", layer_sel, 0);
        check("rst_blank_out", blank_out, 0);
        check("rst_hs_out", hs_out, 1);
        check("rst_vs_out", vs_out, 1);
        check("rst_bg_addr", bg_addr, 0);
        DrawX = 10'd5;
        DrawY = 10'd5;
        #2 Reset_n = 1'b1;
        tick();
        check("post_rst_bg_addr", bg_addr, 642);
        check("post_rst_char_addr", char_addr, 0);
        tick();
        check("post_rst_hs_2cyc", hs_out, 1);
        check("post_rst_blank_2cyc", blank_out, 0);
        tick();
        check("post_rst_hs_3cyc", hs_out, 0);
        check("post_rst_blank_3cyc", blank_out, 1);
        check("post_rst_char_hidden", layer_sel, 0);
        check("post_rst_pal_bg", pal_idx, 4);
        check("post_rst_vs_out", vs_out, 1);
        hs_in = 1'b1;

        // ---- Character at (100,100) ---------------------------------------
        char_x = 10'd100;
        char_y = 10'd100;
        frame_edge();
        present(100, 100);
        check("char_addr_origin", char_addr, 0);
        drain();
        check("char_pal_origin", pal_idx, 5);
        check("char_layer_origin", layer_sel, 2);
        present(131, 131);
        check("char_addr_last", char_addr, 1023);
        drain();
        check("char_layer_last", layer_sel, 2);
        present(132, 100);
        check("char_miss_right_addr", char_addr, 0);
        check("bg_addr_132_100", bg_addr, 16066);
        drain();
        check("char_miss_right_layer", layer_sel, 0);
        check("char_miss_right_pal", pal_idx, 4);
        present(110, 99);
        drain();
        check("char_miss_above_layer", layer_sel, 0);
        char_q = 4'd0;
        present(100, 100);
        drain();
        check("char_transparent_layer", layer_sel, 0);
        check("char_transparent_pal", pal_idx, 4);
        char_q   = 4'd5;
        blank_in = 1'b0;
        present(100, 100);
        drain();
        check("blank_pal", pal_idx, 0);
        check("blank_layer", layer_sel, 0);
        check("blank_out_low", blank_out, 0);
        blank_in = 1'b1;

        // Exact latency: back-to-back pixels hit then miss.
        present(100, 100);
        DrawX = 10'd200;
        DrawY = 10'd200;
        tick();
        tick();
        check("lat_pix1_layer", layer_sel, 2);
        tick();
        check("lat_pix2_layer", layer_sel, 0);

        // ---- Overlap at (200,50): bullet > character > monster ------------
        char_x     = 10'd200;
        char_y     = 10'd50;
        bul_x      = 10'd200;
        bul_y      = 10'd50;
        mon_x      = 10'd200;
        mon_y      = 10'd50;
        bul_active = 1'b1;
        mon_alive  = 1'b1;
        frame_edge();
        bul_q  = 4'd2;
        char_q = 4'd7;
        mon_q  = 4'd9;
        present(203, 52);
        check("ovl_bul_addr", bul_addr, 19);
        check("ovl_char_addr", char_addr, 67);
        check("ovl_mon_addr", mon_addr, 67);
        drain();
        check("ovl_bul_layer", layer_sel, 3);
        check("ovl_bul_pal", pal_idx, 2);
        bul_q = 4'd0;
        present(203, 52);
        drain();
        check("ovl_char_layer", layer_sel, 2);
        check("ovl_char_pal", pal_idx, 7);
        char_q = 4'd0;
        present(203, 52);
        drain();
        check("ovl_mon_layer", layer_sel, 1);
        check("ovl_mon_pal", pal_idx, 9);
        mon_q = 4'd0;
        present(203, 52);
        drain();
        check("ovl_bg_layer", layer_sel, 0);
        check("ovl_bg_pal", pal_idx, 4);
        bul_q  = 4'd2;
        char_q = 4'd7;
        present(208, 52);
        check("bul_miss_addr", bul_addr, 0);
        drain();
        check("bul_miss_char_layer", layer_sel, 2);

        // ---- Monster near the bottom-right corner -------------------------
        mon_x      = 10'd600;
        mon_y      = 10'd470;
        char_x     = 10'd0;
        char_y     = 10'd400;
        bul_active = 1'b0;
        frame_edge();
        mon_q = 4'd6;
        present(631, 479);
        check("mon_corner_addr", mon_addr, 319);
        drain();
        check("mon_corner_layer", layer_sel, 1);
        check("mon_corner_pal", pal_idx, 6);
        present(632, 479);
        check("mon_past_edge_addr", mon_addr, 0);
        drain();
        check("mon_past_edge_layer", layer_sel, 0);

        // Object whose span crosses 1023 must still hit, not wrap.
        mon_x = 10'd1000;
        mon_y = 10'd1000;
        frame_edge();
        present(1010, 1005);
        check("mon_nowrap_addr", mon_addr, 170);
        drain();
        check("mon_nowrap_layer", layer_sel, 1);
        present(10, 0);
        check("nowrap_bg_addr", bg_addr, 5);
        drain();
        check("nowrap_layer", layer_sel, 0);

        // Character clipped at the right edge.
        char_x = 10'd630;
        char_y = 10'd10;
        frame_edge();
        present(639, 10);
        check("char_clip_addr", char_addr, 9);
        drain();
        check("char_clip_layer", layer_sel, 2);
        present(5, 10);
        check("char_clip_wrap_addr", char_addr, 0);
        drain();
        check("char_clip_wrap_layer", layer_sel, 0);

        // ---- Mid-frame position change ------------------------------------
        char_x = 10'd100;
        present(633, 10);
        check("midframe_old_addr", char_addr, 3);
        drain();
        check("midframe_old_layer", layer_sel, 2);
        present(103, 10);
        check("midframe_new_ignored", char_addr, 0);
        // Pixel in flight on the vs edge still uses the old shadow.
        DrawX = 10'd633;
        vs_in = 1'b0;
        tick();
        check("edge_inflight_addr", char_addr, 3);
        vs_in = 1'b1;
        tick();
        check("edge_after_old_pos", char_addr, 0);
        present(103, 10);
        check("edge_after_new_pos", char_addr, 3);

        // ---- Animation ----------------------------------------------------
        do_reset();
        char_x    = 10'd0;
        char_y    = 10'd400;
        mon_x     = 10'd300;
        mon_y     = 10'd200;
        mon_alive = 1'b1;
        mon_q     = 4'd6;
        repeat (7) frame_edge();
        present(300, 200);
        check("anim_7_edges", mon_addr, 0);
        frame_edge();
        present(300, 200);
        check("anim_8_edges", mon_addr, 1024);
        present(301, 201);
        check("anim_8_edges_offset", mon_addr, 1057);
        drain();
        check("anim_layer", layer_sel, 1);
        check("anim_pal", pal_idx, 6);
        repeat (7) frame_edge();
        present(300, 200);
        check("anim_15_edges", mon_addr, 1024);
        frame_edge();
        present(300, 200);
        check("anim_16_edges", mon_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
